// File: rtl/mmio_port_responder_pkg.sv
// Shared constants for the MMIO port responder: register offsets, default base, port width.
package mmio_port_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;
  localparam int unsigned PORT_IN_WIDTH        = 8;

  localparam logic [2:0] OFF_PORT_OUT    = 3'd0;
  localparam logic [2:0] OFF_PORT_IN     = 3'd1;
  localparam logic [2:0] OFF_EDGE_STATUS = 3'd2;
  localparam logic [2:0] OFF_EDGE_COUNT  = 3'd3;
  localparam logic [2:0] OFF_IRQ_ENABLE  = 3'd4;

endpackage

// File: rtl/port_input_synchronizer.sv
// Two-flop synchronizer for asynchronous inputs plus a registered copy for rising-edge detection.
module port_input_synchronizer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_out
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       warm_q;

  // Until the pipeline has filled, prev loads the same value as sync2 so that a
  // level already high at reset release never looks like a rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= warm_q[1] ? sync2_q : sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
    end
  end

  assign sync_out = sync2_q;
  assign rise_out = sync2_q & ~prev_q;

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped responder: PortOut register, synchronized PortIn, sticky edge flags,
// edge counter and interrupt; loads are answered combinationally.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        PortOutStrobe,
  output logic        Interrupt
);

  logic [PORT_IN_WIDTH-1:0] port_in_sync;
  logic [PORT_IN_WIDTH-1:0] port_in_rise;

  logic                     hit;
  logic [2:0]               offset;
  logic                     wr_en;

  logic [31:0]              port_out_q, port_out_d;
  logic                     strobe_q, strobe_d;
  logic [PORT_IN_WIDTH-1:0] status_q, status_d, status_clr;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [PORT_IN_WIDTH-1:0] irq_en_q, irq_en_d;
  logic                     irq_q, irq_d;

  port_input_synchronizer #(
    .WIDTH (PORT_IN_WIDTH)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (PortIn),
    .sync_out (port_in_sync),
    .rise_out (port_in_rise)
  );

  assign hit    = (Address[31:5] == BASE_ADDRESS[31:5]) && (Address[1:0] == 2'b00);
  assign offset = Address[4:2];
  assign wr_en  = MemWrite && hit;

  always_comb begin
    port_out_d = port_out_q;
    strobe_d   = 1'b0;
    status_clr = '0;
    irq_en_d   = irq_en_q;
    if (wr_en) begin
      case (offset)
        OFF_PORT_OUT: begin
          port_out_d = WriteData;
          strobe_d   = 1'b1;
        end
        OFF_EDGE_STATUS: status_clr = WriteData[PORT_IN_WIDTH-1:0];
        OFF_IRQ_ENABLE:  irq_en_d   = WriteData[PORT_IN_WIDTH-1:0];
        default: ;
      endcase
    end
    // A new edge wins over a simultaneous write-1-to-clear.
    status_d = port_in_rise | (status_q & ~status_clr);
    count_d  = (|port_in_rise) ? count_q + COUNT_WIDTH'(1) : count_q;
    irq_d    = |(status_d & irq_en_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q <= '0;
      strobe_q   <= 1'b0;
      status_q   <= '0;
      count_q    <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      strobe_q   <= strobe_d;
      status_q   <= status_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead && hit) begin
      case (offset)
        OFF_PORT_OUT:    ReadData = port_out_q;
        OFF_PORT_IN:     ReadData = 32'(port_in_sync);
        OFF_EDGE_STATUS: ReadData = 32'(status_q);
        OFF_EDGE_COUNT:  ReadData = 32'(count_q);
        OFF_IRQ_ENABLE:  ReadData = 32'(irq_en_q);
        default:         ReadData = '0;
      endcase
    end
  end

  assign PortOut       = port_out_q;
  assign PortOutStrobe = strobe_q;
  assign Interrupt     = irq_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder; load results go through an expected-value queue.
module tb_mmio_port_responder;
  import mmio_port_responder_pkg::*;

  localparam logic [31:0] BASE = DEFAULT_BASE_ADDRESS;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        PortOutStrobe;
  logic        Interrupt;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        sb[$];
  int          n_checks;
  int          n_fail;
  int unsigned exp_count;
  int unsigned n_toggles;

  mmio_port_responder #(
    .BASE_ADDRESS (BASE),
    .COUNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Address       (Address),
    .WriteData     (WriteData),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .ReadData      (ReadData),
    .PortIn        (PortIn),
    .PortOut       (PortOut),
    .PortOutStrobe (PortOutStrobe),
    .Interrupt     (Interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    sb.push_back('{tag, exp});
    Address = addr;
    MemRead = 1'b1;
    #1;
    e = sb.pop_front();
    check_eq(e.tag, ReadData, e.value);
    MemRead = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;
    reset     = 1'b0;
    Address   = '0;
    WriteData = '0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = '0;
    #1 reset = 1'b1;
    #1;
    check_eq("rst_port_out", PortOut, 32'h0);
    check_eq("rst_strobe", {31'b0, PortOutStrobe}, 32'h0);
    check_eq("rst_irq", {31'b0, Interrupt}, 32'h0);
    load("rst_rd_status", BASE + 32'h8, 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(3);

    // PORT_OUT write, strobe and readback
    store(BASE, 32'hDEAD_BEEF);
    check_eq("port_out_val", PortOut, 32'hDEAD_BEEF);
    check_eq("strobe_high", {31'b0, PortOutStrobe}, 32'h1);
    tick();
    check_eq("strobe_low", {31'b0, PortOutStrobe}, 32'h0);
    load("port_out_rd", BASE, 32'hDEAD_BEEF);
    Address = BASE;
    #1;
    check_eq("no_memread_zero", ReadData, 32'h0);

    // back-to-back writes keep the strobe high
    store(BASE, 32'h1);
    check_eq("b2b_strobe1", {31'b0, PortOutStrobe}, 32'h1);
    store(BASE, 32'h2);
    check_eq("b2b_strobe2", {31'b0, PortOutStrobe}, 32'h1);
    check_eq("b2b_port_out", PortOut, 32'h2);
    tick();
    check_eq("b2b_strobe_end", {31'b0, PortOutStrobe}, 32'h0);

    // read during write shows the old value, new value next cycle
    WriteData = 32'h11;
    MemWrite  = 1'b1;
    load("rdw_old", BASE, 32'h2);
    tick();
    MemWrite  = 1'b0;
    load("rdw_new", BASE, 32'h11);

    store(BASE + 32'h10, 32'hFFFF_FF04);
    load("irq_en_rd", BASE + 32'h10, 32'h4);

    // PortIn 0x00 -> 0x05
    PortIn = 8'h05;
    tick();
    load("port_in_1edge", BASE + 32'h4, 32'h0);
    tick();
    load("port_in_2edge", BASE + 32'h4, 32'h5);
    load("status_2edge", BASE + 32'h8, 32'h0);
    check_eq("irq_2edge", {31'b0, Interrupt}, 32'h0);
    tick();
    exp_count = 1;
    load("status_3edge", BASE + 32'h8, 32'h5);
    load("count_3edge", BASE + 32'hC, exp_count);
    check_eq("irq_3edge", {31'b0, Interrupt}, 32'h1);

    // clear bit0 while it re-rises: the set wins
    PortIn = 8'h04;
    ticks(3);
    PortIn = 8'h05;
    ticks(2);
    store(BASE + 32'h8, 32'h1);
    exp_count = 2;
    load("w1c_set_wins", BASE + 32'h8, 32'h5);
    load("count_rerise", BASE + 32'hC, exp_count);
    check_eq("irq_before_clr", {31'b0, Interrupt}, 32'h1);
    store(BASE + 32'h8, 32'h4);
    load("w1c_clear", BASE + 32'h8, 32'h1);
    check_eq("irq_after_clr", {31'b0, Interrupt}, 32'h0);

    // alternate 0xAA/0x55 so every cycle has a rise, up to the counter maximum
    n_toggles = 32'hFFFF - exp_count;
    for (int unsigned k = 1; k <= n_toggles; k++) begin
      PortIn = (k % 2 == 1) ? 8'hAA : 8'h55;
      tick();
    end
    exp_count = exp_count + n_toggles;
    ticks(3);
    load("count_max", BASE + 32'hC, exp_count);
    PortIn = (PortIn == 8'hAA) ? 8'h55 : 8'hAA;
    ticks(3);
    exp_count = (exp_count + 1) & 32'hFFFF;
    load("count_wrap", BASE + 32'hC, exp_count);
    load("status_all", BASE + 32'h8, 32'hFF);
    check_eq("irq_all", {31'b0, Interrupt}, 32'h1);

    // dropped accesses
    store(BASE + 32'h2, 32'hFFFF_FFFF);
    check_eq("misalign_port_out", PortOut, 32'h11);
    check_eq("misalign_strobe", {31'b0, PortOutStrobe}, 32'h0);
    store(BASE + 32'h20, 32'hFFFF_FFFF);
    check_eq("miss_port_out", PortOut, 32'h11);
    check_eq("miss_strobe", {31'b0, PortOutStrobe}, 32'h0);
    store(BASE + 32'h4, 32'hFFFF_FFFF);
    check_eq("ro_strobe", {31'b0, PortOutStrobe}, 32'h0);
    load("ro_port_in", BASE + 32'h4, {24'h0, PortIn});
    store(BASE + 32'hA, 32'hFF);
    load("misalign_w1c", BASE + 32'h8, 32'hFF);
    store(BASE + 32'hC, 32'h1234);
    load("count_ro", BASE + 32'hC, exp_count);
    store(BASE + 32'h18, 32'hFFFF);
    load("rsvd_rd", BASE + 32'h18, 32'h0);
    load("misalign_rd", BASE + 32'h2, 32'h0);
    load("miss_rd", BASE + 32'h20, 32'h0);

    // asynchronous reset mid-cycle
    store(BASE, 32'h1234_5678);
    PortIn = 8'hFF;
    ticks(4);
    check_eq("pre_rst_port_out", PortOut, 32'h1234_5678);
    check_eq("pre_rst_irq", {31'b0, Interrupt}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_port_out", PortOut, 32'h0);
    check_eq("arst_strobe", {31'b0, PortOutStrobe}, 32'h0);
    check_eq("arst_irq", {31'b0, Interrupt}, 32'h0);
    load("arst_status", BASE + 32'h8, 32'h0);
    load("arst_count", BASE + 32'hC, 32'h0);
    ticks(2);
    reset = 1'b0;
    ticks(6);
    load("post_rst_status", BASE + 32'h8, 32'h0);
    load("post_rst_port_in", BASE + 32'h4, 32'hFF);
    load("post_rst_count", BASE + 32'hC, 32'h0);
    check_eq("post_rst_irq", {31'b0, Interrupt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
